// File: rtl/hamming_dec_engine.sv
// Memory-walking Hamming(15,11) decoder: reads NUM_WORDS codewords, corrects single-bit errors, writes messages back.
// Optional HAMMING_ERRFLAG_EN: flags corrected words in bit 7 of the high byte and counts them on o_err_cnt.
module hamming_dec_engine #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 94
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_init,
  output logic          o_done,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_wdata,
`ifdef HAMMING_ERRFLAG_EN
  output logic [7:0]    o_err_cnt,
`endif
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI, S_DONE} state_t;

  localparam logic [AW-1:0] SRC = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST = AW'(DST_BASE);

  state_t      r_state, w_next;
  logic [5:0]  r_idx;
  logic [7:0]  r_lo;
  logic [6:0]  r_hi;
  logic        r_done;
  logic        w_start;
  logic        w_last;
  logic [15:1] w_cw;
  logic [3:0]  w_syn;
  logic [10:0] w_dat;
  logic        w_flag;
  logic [AW-1:0] w_src, w_dst;

  assign w_start = i_init && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last  = (r_idx == 6'(NUM_WORDS - 1));
  assign w_cw    = {r_hi, r_lo};
  assign w_src   = SRC + AW'({r_idx, 1'b0});
  assign w_dst   = DST + AW'({r_idx, 1'b0});
  assign o_done  = r_done;

  always_comb begin
    w_syn = '0;
    for (int k = 1; k < 16; k++)
      if (w_cw[k]) w_syn = w_syn ^ 4'(k);
  end

  // Walk the non-power-of-two positions in order; correction is applied per bit.
  always_comb begin
    int j;
    j     = 0;
    w_dat = '0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        w_dat[j] = w_cw[k] ^ (w_syn == 4'(k));
        j++;
      end
    end
  end

`ifdef HAMMING_ERRFLAG_EN
  assign w_flag = (w_syn != 4'd0);
`else
  assign w_flag = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    case (r_state)
      S_IDLE, S_DONE: if (i_init) w_next = S_RD_LO;
      S_RD_LO: begin
        o_mem_addr = w_src;
        w_next     = S_RD_HI;
      end
      S_RD_HI: begin
        o_mem_addr = w_src + AW'(1);
        w_next     = S_WR_LO;
      end
      S_WR_LO: begin
        o_mem_addr  = w_dst;
        o_mem_wen   = 1'b1;
        o_mem_wdata = DW'(w_dat[7:0]);
        w_next      = S_WR_HI;
      end
      S_WR_HI: begin
        o_mem_addr  = w_dst + AW'(1);
        o_mem_wen   = 1'b1;
        o_mem_wdata = DW'({w_flag, 4'b0000, w_dat[10:8]});
        w_next      = w_last ? S_DONE : S_RD_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef HAMMING_ERRFLAG_EN
  logic [7:0] r_err_cnt;
  assign o_err_cnt = r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)                            r_err_cnt <= '0;
    else if (w_start)                       r_err_cnt <= '0;
    else if (r_state == S_WR_HI && w_flag)  r_err_cnt <= r_err_cnt + 8'd1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start)                 r_done <= 1'b0;
      else if (r_state == S_DONE)  r_done <= 1'b1;
      if (w_start)                 r_idx <= '0;
      else if (r_state == S_WR_HI) r_idx <= r_idx + 6'd1;
      if (r_state == S_RD_LO)      r_lo <= i_mem_rdata[7:0];
      if (r_state == S_RD_HI)      r_hi <= i_mem_rdata[6:0];
    end
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench: an encoder-based reference model predicts every memory write; a monitor checks them.
module tb_hamming_dec_engine;
  localparam int N   = 15;
  localparam int SRC = 64;
  localparam int DST = 94;

  logic       clk = 1'b0;
  logic       reset, init;
  logic       done, wen;
  logic [7:0] addr, wdata, rdata;
`ifdef HAMMING_ERRFLAG_EN
  logic [7:0] err_cnt;
`endif

  hamming_dec_engine dut (
    .i_clk(clk), .i_reset(reset), .i_init(init), .o_done(done),
    .o_mem_addr(addr), .o_mem_wen(wen), .o_mem_wdata(wdata),
`ifdef HAMMING_ERRFLAG_EN
    .o_err_cnt(err_cnt),
`endif
    .i_mem_rdata(rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  assign rdata = mem[addr];
  always @(posedge clk) if (wen) mem[addr] <= wdata;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q [$];
  logic [10:0] w_msg [N];
  bit          w_err [N];

  // Standard Hamming encoder: data in non-power-of-two slots, even parity at 1,2,4,8.
  function automatic logic [15:1] enc(input logic [10:0] m);
    logic [15:1] c;
    logic        b;
    int          j;
    c = '0;
    j = 0;
    for (int k = 1; k < 16; k++)
      if ((k & (k - 1)) != 0) begin c[k] = m[j]; j++; end
    for (int p = 1; p < 16; p = p * 2) begin
      b = 1'b0;
      for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) b = b ^ c[k];
      c[p] = b;
    end
    return c;
  endfunction

  task automatic load(input int w, input logic [10:0] m, input int flip, input bit h7);
    logic [15:1] c;
    c = enc(m);
    if (flip != 0) c[flip] = ~c[flip];
    mem[SRC + 2*w]     = c[8:1];
    mem[SRC + 2*w + 1] = {h7, c[15:9]};
    w_msg[w] = m;
    w_err[w] = (flip != 0);
  endtask

  task automatic push_words(input int nw);
    bit f;
    for (int w = 0; w < nw; w++) begin
`ifdef HAMMING_ERRFLAG_EN
      f = w_err[w];
`else
      f = 1'b0;
`endif
      exp_q.push_back({8'(DST + 2*w), w_msg[w][7:0]});
      exp_q.push_back({8'(DST + 2*w + 1), {f, 4'b0000, w_msg[w][10:8]}});
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (wen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%02h", addr, wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({addr, wdata} !== e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%02h want addr=%0d data=%02h",
                   addr, wdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  // Pulse init, optionally pulse it again while busy, and time the rise of done.
  task automatic run(input int busy_at);
    int n;
    push_words(N);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    chk("done_clear", done, 0);
    n = 0;
    while (!done && n < 200) begin
      if (n == busy_at) init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      n++;
    end
    chk("done_latency", n, 61);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nerr;
    reset = 1'b1;
    init  = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_wen", wen, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < N; w++) load(w, 11'($urandom_range(0, 2047)), 0, 1'b0);
    run(-1);

    for (int w = 0; w < N; w++) load(w, 11'h7FF, w + 1, 1'b0);
    run(-1);
`ifdef HAMMING_ERRFLAG_EN
    chk("err_cnt_all", err_cnt, 15);
`endif

    for (int w = 0; w < N; w++) load(w, 11'($urandom_range(0, 2047)), 0, bit'(w % 2));
    run(10);
    run(-1);

    nerr = 0;
    for (int w = 0; w < N; w++) begin
      int f;
      f = (w % 3 == 0) ? $urandom_range(1, 15) : 0;
      if (f != 0) nerr++;
      load(w, 11'($urandom_range(0, 2047)), f, bit'($urandom_range(0, 1)));
    end
    run(-1);
`ifdef HAMMING_ERRFLAG_EN
    chk("err_cnt_mixed", err_cnt, nerr);
`endif

    push_words(5);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wen", wen, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_queue", exp_q.size(), 0);
    chk("idle_wen", wen, 0);
    run(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
